alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 189 ++++++++++++++++++
 tb/tb_alu_seq.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : command sequencer for an external combinational ALU.
//
// Commands {op, a, b, acc} are queued in a 4-entry FIFO. One command at a
// time is popped into registered ALU drive lines. The ALU then gets one full
// cycle to settle, and its result and flags are captured into a held result
// register. That result stays valid until the consumer accepts it.
//
// Optional feature (macro ALU_SEQ_ACC_EN): a 4-bit accumulator tracks the last
// captured result. A command with cmd_acc=1 then uses the accumulator as
// operand A instead of cmd_a.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid/cmd_ready command handshake (cmd_ready is combinational)
//   cmd_op,cmd_a,cmd_b  operator (8-15 illegal) and operands
//   cmd_acc             use accumulator as operand A (ALU_SEQ_ACC_EN only)
//   alu_a,alu_b,alu_op  registered drive to the downstream ALU
//   alu_result, alu_carry, alu_overflow, alu_zero   ALU outputs
//   res_valid/res_ready result handshake
//   res_data            captured result
//   res_flags           {err, carry, overflow, zero}
// ---------------------------------------------------------------------------
module alu_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_op,
   input  logic [3:0] cmd_a,
   input  logic [3:0] cmd_b,
   input  logic       cmd_acc,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [3:0] alu_op,
   input  logic [3:0] alu_result,
   input  logic       alu_carry,
   input  logic       alu_overflow,
   input  logic       alu_zero,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [3:0] res_data,
   output logic [3:0] res_flags
);

   localparam int unsigned DW    = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned PTRW  = 2;
   localparam int unsigned CNTW  = 3;

   typedef struct packed {
      logic [DW-1:0] op;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic          acc;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

   state_t            state, state_nx;
   cmd_t              fifo_mem [DEPTH];
   cmd_t              head;
   logic [PTRW-1:0]   wr_ptr, rd_ptr;
   logic [CNTW-1:0]   count;
   logic              push, pop, capture, fifo_empty;
   logic [DW-1:0]     a_sel;
   logic [DW-1:0]     cap_data;
   logic [DW-1:0]     cap_flags;

   // Readiness depends only on occupancy, so a full FIFO never passes through.
   assign cmd_ready  = (count < CNTW'(DEPTH)) && !rst;
   assign push       = cmd_valid && cmd_ready;
   assign fifo_empty = (count == '0);
   assign head       = fifo_mem[rd_ptr];

   // Next-state and pop/capture decode
   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      capture  = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop      = 1'b1;
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            capture  = 1'b1;
            state_nx = HOLD;
         end
         HOLD: begin
            if (res_ready) begin
               if (!fifo_empty) begin
                  pop      = 1'b1;
                  state_nx = ISSUE;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // FIFO storage; contents need no reset since occupancy guards reads
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b, acc: cmd_acc};
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTRW'(1);
         if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
         case ({push, pop})
            2'b10:   count <= count + CNTW'(1);
            2'b01:   count <= count - CNTW'(1);
            default: count <= count;
         endcase
      end
   end

   // Illegal operators capture a zero result with only the error flag set.
   always_comb begin
      cap_data  = alu_result;
      cap_flags = {1'b0, alu_carry, alu_overflow, alu_zero};
      if (alu_op[3]) begin
         cap_data  = '0;
         cap_flags = 4'b1000;
      end
   end

`ifdef ALU_SEQ_ACC_EN
   logic [DW-1:0] acc_q;

   // Accumulator follows every captured result
   always_ff @(posedge clk) begin
      if (rst)          acc_q <= '0;
      else if (capture) acc_q <= cap_data;
   end

   assign a_sel = head.acc ? acc_q : head.a;
`else
   logic unused_acc;

   assign unused_acc = head.acc;
   assign a_sel      = head.a;
`endif

   // ALU drive registers, loaded only on pop
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_a  <= '0;
         alu_b  <= '0;
         alu_op <= '0;
      end else if (pop) begin
         alu_a  <= a_sel;
         alu_b  <= head.b;
         alu_op <= head.op;
      end
   end

   // Result register: set on capture, cleared on consumer acceptance
   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_flags <= '0;
      end else if (capture) begin
         res_valid <= 1'b1;
         res_data  <= cap_data;
         res_flags <= cap_flags;
      end else if ((state == HOLD) && res_ready) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq : self-checking bench for alu_seq.
// The bench supplies a combinational ALU. A result scoreboard is computed in
// command order at push time. Around it the bench runs table vectors,
// hand-written sequences for full/back-to-back/reset, and a random phase.
// Honors ALU_SEQ_ACC_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_ready, cmd_acc;
   logic [3:0] cmd_op, cmd_a, cmd_b;
   logic [3:0] alu_a, alu_b, alu_op, alu_result;
   logic       alu_carry, alu_overflow, alu_zero;
   logic       res_valid, res_ready;
   logic [3:0] res_data, res_flags;

`ifdef ALU_SEQ_ACC_EN
   localparam bit ACC_EN = 1'b1;
`else
   localparam bit ACC_EN = 1'b0;
`endif

   int total = 0;
   int bad   = 0;
   int n_results = 0;

   logic [7:0] exp_q[$];
   logic [3:0] model_acc;
   logic       prev_stall;
   logic [3:0] prev_data, prev_flags;

   typedef struct {
      logic [3:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] exp_data;
      logic [3:0] exp_flags;
   } vec_t;

   vec_t tbl[12];

   alu_seq dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_carry(alu_carry),
      .alu_overflow(alu_overflow), .alu_zero(alu_zero),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_flags(res_flags)
   );

   always #5 clk = ~clk;

   // Downstream ALU: {carry, overflow, zero, result}; illegal codes give garbage
   function automatic logic [6:0] alu_fn(input logic [3:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
      int s;
      logic [3:0] r;
      logic c, v;
      c = 1'b0;
      v = 1'b0;
      case (op)
         4'd0: begin s = int'(a) + int'(b); r = 4'(s); c = (s > 15);
                     v = (a[3] == b[3]) && (r[3] != a[3]); end
         4'd1: begin r = a - b; c = (a < b); v = (a[3] != b[3]) && (r[3] != a[3]); end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: begin r = {a[2:0], 1'b0}; c = a[3]; end
         4'd6: begin r = {1'b0, a[3:1]}; c = a[0]; end
         4'd7: r = b;
         default: begin r = ~(a + b + op); c = 1'b1; v = 1'b1; end
      endcase
      return {c, v, (r == 4'd0), r};
   endfunction

   // Expected {flags, data} of one command
   function automatic logic [7:0] ref_res(input logic [3:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
      if (op[3]) return {4'b1000, 4'h0};
      return {1'b0, alu_fn(op, a, b)};
   endfunction

   always_comb {alu_carry, alu_overflow, alu_zero, alu_result} = alu_fn(alu_op, alu_a, alu_b);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Scoreboard: results must come out in push order; held results stay stable
   always @(negedge clk) begin
      logic [7:0] e;
      logic [3:0] a_eff;
      if (rst) begin
         exp_q.delete();
         model_acc  = 4'h0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_data", 32'(res_data), 32'(prev_data));
            chk("hold_flags", 32'(res_flags), 32'(prev_flags));
         end
         if (res_valid && res_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL spurious_result: got data %0h with nothing outstanding", res_data);
            end else begin
               e = exp_q.pop_front();
               n_results++;
               if ({res_flags, res_data} !== e) begin
                  bad++;
                  $display("FAIL result: got flags %b data %0h expected flags %b data %0h",
                           res_flags, res_data, e[7:4], e[3:0]);
               end
            end
         end
         if (cmd_valid && cmd_ready) begin
            a_eff = (ACC_EN && cmd_acc) ? model_acc : cmd_a;
            e = ref_res(cmd_op, a_eff, cmd_b);
            exp_q.push_back(e);
            model_acc = e[3:0];
         end
         chk("outstanding_le5", 32'(exp_q.size() <= 5), 32'd1);
         prev_stall = res_valid && !res_ready;
         prev_data  = res_data;
         prev_flags = res_flags;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic acc);
      bit done;
      done = 1'b0;
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = acc;
      for (int n = 0; n < 50 && !done; n++) begin
         if (cmd_ready) done = 1'b1;
         tick();
      end
      cmd_valid = 1'b0;
      chk("push_accepted", 32'(done), 32'd1);
   endtask

   task automatic wait_res(input string name);
      bit seen;
      seen = res_valid;
      for (int n = 0; n < 50 && !seen; n++) begin
         tick();
         seen = res_valid;
      end
      chk(name, 32'(seen), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      tbl[0]  = '{4'd0, 4'd3,  4'd4,  4'd7,  4'b0000};
      tbl[1]  = '{4'd0, 4'd8,  4'd8,  4'd0,  4'b0111};
      tbl[2]  = '{4'd1, 4'd5,  4'd7,  4'd14, 4'b0100};
      tbl[3]  = '{4'd2, 4'd12, 4'd10, 4'd8,  4'b0000};
      tbl[4]  = '{4'd3, 4'd0,  4'd0,  4'd0,  4'b0001};
      tbl[5]  = '{4'd4, 4'd15, 4'd15, 4'd0,  4'b0001};
      tbl[6]  = '{4'd5, 4'd9,  4'd2,  4'd2,  4'b0100};
      tbl[7]  = '{4'd6, 4'd3,  4'd6,  4'd1,  4'b0100};
      tbl[8]  = '{4'd7, 4'd6,  4'd0,  4'd0,  4'b0001};
      tbl[9]  = '{4'd9, 4'd5,  4'd5,  4'd0,  4'b1000};
      tbl[10] = '{4'd15, 4'd0, 4'd0,  4'd0,  4'b1000};
      tbl[11] = '{4'd0, 4'd7,  4'd1,  4'd8,  4'b0010};

      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 4'd0; cmd_b = 4'd0;
      cmd_acc = 1'b0; res_ready = 1'b1;
      repeat (3) tick();
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_data", 32'(res_data), 32'd0);
      chk("rst_res_flags", 32'(res_flags), 32'd0);
      chk("rst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

      // Table: single commands with exact latency from an idle, empty sequencer
      for (int i = 0; i < 12; i++) begin
         cmd_valid = 1'b1; cmd_op = tbl[i].op; cmd_a = tbl[i].a; cmd_b = tbl[i].b;
         chk("tbl_ready", 32'(cmd_ready), 32'd1);
         tick();
         cmd_valid = 1'b0;
         chk("tbl_lat1_valid", 32'(res_valid), 32'd0);
         tick();
         chk("tbl_alu_drive", 32'({alu_op, alu_a, alu_b}), 32'({tbl[i].op, tbl[i].a, tbl[i].b}));
         chk("tbl_lat2_valid", 32'(res_valid), 32'd0);
         tick();
         chk("tbl_valid", 32'(res_valid), 32'd1);
         chk("tbl_data", 32'(res_data), 32'(tbl[i].exp_data));
         chk("tbl_flags", 32'(res_flags), 32'(tbl[i].exp_flags));
         tick();
         chk("tbl_consumed", 32'(res_valid), 32'd0);
         chk("tbl_data_held", 32'(res_data), 32'(tbl[i].exp_data));
      end

      // Fill with consumer stalled: 4 queued plus 1 in flight, then back-to-back drain
      res_ready = 1'b0;
      base = n_results;
      for (int i = 0; i < 5; i++) begin
         cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 4'(i + 1); cmd_b = 4'd2; cmd_acc = 1'b0;
         chk("fill_ready", 32'(cmd_ready), 32'd1);
         tick();
      end
      chk("full_ready", 32'(cmd_ready), 32'd0);
      cmd_op = 4'd1; cmd_a = 4'd9; cmd_b = 4'd3;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("full_stall_ready", 32'(cmd_ready), 32'd0);
      end
      chk("full_res_valid", 32'(res_valid), 32'd1);
      chk("full_res_data", 32'(res_data), 32'd3);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("after_pop_ready", 32'(cmd_ready), 32'd1);
      chk("b2b_gap_first", 32'(res_valid), 32'd0);
      tick();
      cmd_valid = 1'b0;
      chk("sixth_issue_valid", 32'(res_valid), 32'd1);
      res_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk("b2b_valid", 32'(res_valid), 32'd1);
         tick();
         if (k < 4) begin
            chk("b2b_gap", 32'(res_valid), 32'd0);
            tick();
         end
      end
      repeat (3) tick();
      chk("b2b_idle", 32'(res_valid), 32'd0);
      chk("b2b_count", 32'(n_results - base), 32'd6);
      chk("b2b_all_delivered", 32'(exp_q.size()), 32'd0);

      // Reset while holding a result with three commands queued
      res_ready = 1'b0;
      push_cmd(4'd0, 4'd3, 4'd4, 1'b0);
      push_cmd(4'd2, 4'd15, 4'd6, 1'b0);
      push_cmd(4'd3, 4'd1, 4'd8, 1'b0);
      push_cmd(4'd4, 4'd5, 4'd3, 1'b0);
      wait_res("hold_reached");
      chk("hold_data_pre_rst", 32'(res_data), 32'd7);
      rst = 1'b1; cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 4'd1; cmd_b = 4'd1;
      tick();
      chk("midrst_res_valid", 32'(res_valid), 32'd0);
      chk("midrst_res_data", 32'(res_data), 32'd0);
      chk("midrst_res_flags", 32'(res_flags), 32'd0);
      chk("midrst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
      rst = 1'b0; cmd_valid = 1'b0;
      #1;
      chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
      res_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("midrst_quiet", 32'(res_valid), 32'd0);
      end

      // Accumulator chaining (falls back to cmd_a when the feature is off)
      push_cmd(4'd0, 4'd2, 4'd3, 1'b0);
      push_cmd(4'd0, 4'd9, 4'd1, 1'b1);
      wait_res("acc_first_seen");
      chk("acc_first", 32'(res_data), 32'd5);
      tick();
      wait_res("acc_second_seen");
      chk("acc_second", 32'(res_data), ACC_EN ? 32'd6 : 32'd10);
      tick();

      // Random traffic against the scoreboard
      for (int i = 0; i < 400; i++) begin
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_op    = 4'($urandom_range(0, 15));
         cmd_a     = 4'($urandom_range(0, 15));
         cmd_b     = 4'($urandom_range(0, 15));
         cmd_acc   = 1'($urandom_range(0, 1));
         res_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      for (int n = 0; n < 60 && (exp_q.size() != 0 || res_valid); n++) tick();
      chk("rand_drained", 32'(exp_q.size()), 32'd0);
      chk("rand_idle", 32'(res_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
